// File: rtl/mem_lsu.sv
// Byte-addressed load/store adapter onto a word-addressed memory port without byte enables.
// Sub-word stores are read-modify-write; misaligned or illegal requests get an error response.
module mem_lsu #(
    parameter int MEM_ADDR_W = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wr,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE, S_ERR
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    state_e                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [1:0]              size_q, size_d;
    logic                    wr_q, wr_d;
    logic                    signed_q, signed_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic [31:0]             resp_data_q, resp_data_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    mem_wr_q, mem_wr_d;

    logic        req_bad;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] merged;

    assign req_bad = (req_size == SZ_ILL)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    assign rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    assign rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_BYTE) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else                   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_comb begin
        // NOTE: every _d starts from its hold/idle value so no path leaves a signal unassigned (no latch).
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        wr_d         = wr_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = resp_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_d     = 1'b0;

        case (state_q)
            S_IDLE: if (req_valid) begin
                lane_d      = req_addr[1:0];
                size_d      = req_size;
                wr_d        = req_wr;
                signed_d    = req_signed;
                wdata_d     = req_wdata[15:0];
                resp_data_d = '0;
                if (req_bad) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    state_d      = S_ERR;
                end else begin
                    mem_addr_d = req_addr[MEM_ADDR_W+1:2];
                    if (req_wr && req_size == SZ_WORD) begin
                        mem_wdata_d = req_wdata;
                        mem_wr_d    = 1'b1;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                if (wr_q) begin
                    mem_wdata_d = merged;
                    mem_wr_d    = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    case (size_q)
                        SZ_BYTE: resp_data_d = {{24{signed_q & rd_byte[7]}}, rd_byte};
                        SZ_HALF: resp_data_d = {{16{signed_q & rd_half[15]}}, rd_half};
                        default: resp_data_d = mem_rdata;
                    endcase
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            size_q       <= '0;
            wr_q         <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            wr_q         <= wr_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized requests
// compared against an array-based reference model of memory and load/store rules.
module tb_mem_lsu;

    localparam int MEM_ADDR_W = 30;
    localparam int MEM_WORDS  = 2048;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  req_wr;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_err;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_wr;
    logic [31:0]           mem_rdata;

    mem_lsu #(.MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memcontrol stand-in: synchronous read, wraps at 2K words
    logic [31:0] tb_mem  [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_addr[10:0]] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr[10:0]];
    end

    int n_checks = 0;
    int n_errors = 0;

    int          obs_lat;
    int          obs_wrs;
    logic [31:0] obs_data;
    logic [31:0] obs_waddr;
    logic [31:0] obs_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'((a / 32'd4) % MEM_WORDS);
    endfunction

    function automatic bit is_bad(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (a % 2) != 0;
        if (size == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] a, input logic sgn);
        logic [31:0] w, v;
        w = ref_mem[word_idx(a)];
        if (size == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w, mask;
        int sh;
        w = ref_mem[word_idx(a)];
        if (size == 2'd2) return d;
        if (size == 2'd0) begin
            sh = 8 * int'(a % 4);
            mask = 32'hFF << sh;
        end else begin
            sh = 16 * int'((a / 2) % 2);
            mask = 32'hFFFF << sh;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    // Drive one request, hold req_valid until the response, compare against the model.
    task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] a,
                           input logic sgn, input logic [31:0] d);
        bit          bad;
        int          exp_lat, exp_wrs, idx;
        logic [31:0] exp_data;
        logic        got_err;
        bit          found;

        bad = is_bad(size, a);
        idx = word_idx(a);
        exp_data = (bad || wr) ? 32'd0 : ref_load(size, a, sgn);
        exp_wrs  = (!bad && wr) ? 1 : 0;
        if (bad)                    exp_lat = 1;
        else if (wr && size == 2'd2) exp_lat = 2;
        else if (!wr)               exp_lat = 3;
        else                        exp_lat = 4;

        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_addr   = a;
        req_wr     = wr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = d;
        req_valid  = 1'b1;
        @(posedge clk);

        obs_lat = 0; obs_wrs = 0; found = 0; got_err = 1'bx;
        obs_data = 'x; obs_waddr = 'x; obs_wdata = 'x;
        for (int c = 1; c <= 8 && !found; c++) begin
            @(negedge clk);
            if (mem_wr) begin
                obs_wrs++;
                obs_waddr = {{(32-MEM_ADDR_W){1'b0}}, mem_addr};
                obs_wdata = mem_wdata;
            end
            check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (resp_valid) begin
                found     = 1;
                obs_lat   = c;
                obs_data  = resp_data;
                got_err   = resp_err;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;

        check("latency", obs_lat, exp_lat);
        check("resp_err", {31'd0, got_err}, {31'd0, bad});
        check("resp_data", obs_data, exp_data);
        check("mem_wr_cycles", obs_wrs, exp_wrs);
        if (exp_wrs == 1) begin
            ref_mem[idx] = ref_store(size, a, d);
            check("write_addr", obs_waddr, a / 32'd4);
            check("write_data", obs_wdata, ref_mem[idx]);
            check("mem_word", tb_mem[idx], ref_mem[idx]);
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < MEM_WORDS; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0;
        req_size = '0; req_signed = 1'b0; req_wdata = '0; mem_rdata = '0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_mem_wr", {31'd0, mem_wr}, 32'd0);

        // 2: word store then word load
        run_txn(1'b1, 2'd2, 32'h10, 1'b0, 32'hDEAD_BEEF);
        check("t2_lat", obs_lat, 2);
        check("t2_waddr", obs_waddr, 32'h4);
        check("t2_wdata", obs_wdata, 32'hDEAD_BEEF);
        run_txn(1'b0, 2'd2, 32'h10, 1'b0, 32'h0);
        check("t2_load", obs_data, 32'hDEAD_BEEF);
        check("t2_load_lat", obs_lat, 3);

        // 3: byte read-modify-write and extension
        run_txn(1'b1, 2'd2, 32'h10, 1'b0, 32'h1122_3344);
        run_txn(1'b1, 2'd0, 32'h13, 1'b0, 32'h0000_00A5);
        check("t3_merge", obs_wdata, 32'hA522_3344);
        check("t3_lat", obs_lat, 4);
        run_txn(1'b0, 2'd0, 32'h13, 1'b1, 32'h0);
        check("t3_lb", obs_data, 32'hFFFF_FFA5);
        run_txn(1'b0, 2'd0, 32'h13, 1'b0, 32'h0);
        check("t3_lbu", obs_data, 32'h0000_00A5);

        // 4: half read-modify-write and extension
        run_txn(1'b1, 2'd2, 32'h14, 1'b0, 32'h7766_5566);
        run_txn(1'b1, 2'd1, 32'h16, 1'b0, 32'h0000_8001);
        check("t4_merge", obs_wdata, 32'h8001_5566);
        run_txn(1'b0, 2'd1, 32'h16, 1'b1, 32'h0);
        check("t4_lh", obs_data, 32'hFFFF_8001);
        run_txn(1'b0, 2'd1, 32'h16, 1'b0, 32'h0);
        check("t4_lhu", obs_data, 32'h0000_8001);

        // 5: error responses
        run_txn(1'b0, 2'd2, 32'h6, 1'b0, 32'h0);
        check("t5_lw_mis_lat", obs_lat, 1);
        run_txn(1'b1, 2'd1, 32'h3, 1'b0, 32'h1234);
        check("t5_sh_mis_wrs", obs_wrs, 0);
        run_txn(1'b1, 2'd3, 32'h8, 1'b1, 32'h5555_AAAA);
        check("t5_size3_data", obs_data, 32'd0);

        // 6: reset during WRITE of a byte store aborts it
        run_txn(1'b1, 2'd2, 32'h20, 1'b0, 32'h1122_3344);
        @(negedge clk);
        req_addr = 32'h21; req_wr = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_wdata = 32'hEE; req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("t6_ready_busy", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        check("t6_in_write", {31'd0, mem_wr}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_mem_wr_async", {31'd0, mem_wr}, 32'd0);
        check("t6_no_resp", {31'd0, resp_valid}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_mem_unchanged", tb_mem[8], 32'h1122_3344);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_no_resp_after", {31'd0, resp_valid}, 32'd0);
        check("t6_idle", {31'd0, req_ready}, 32'd1);

        // randomized requests; upper address bits exercise the 2K-word wrap
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    $urandom & 32'hFFFF_E03F, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
